dcache_burst_reader: RTL and testbench

- Load-side initiator for one std_nbdcache core request port (dcache_req_i_t / dcache_req_o_t).
- Turns a single command (start address, word count) into a sequence of 64-bit cached loads using the index/tag two-phase protocol.
- Streams the returned words out over a valid/ready interface.
- Used by debug/scan and line-dump logic that needs bulk reads through the cache without going through the LSU.

---
 rtl/dcache_burst_reader.sv | 248 ++++++++++++++++++++++++
 tb/tb_dcache_burst_reader.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_burst_reader.sv
// -----------------------------------------------------------------------------
// dcache_burst_reader
//
// Load-side initiator for one std_nbdcache core request port. A single command
// (start byte address, 64-bit word count) is turned into a sequence of cached
// loads. Each load uses the cache's two-phase protocol: an index phase that
// holds data_req until data_gnt, then a one-cycle tag phase. The returned words
// are streamed out over a valid/ready interface. At most one cache access is
// outstanding at any time.
//
// The request/response structs (dcache_req_i_t / dcache_req_o_t) are flattened
// into plain ports named req_port_o_<field> / req_port_i_<field>.
//
// Ports
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o   command handshake (ready only in IDLE)
//   cmd_addr_i                  start byte address, bits [2:0] ignored
//   cmd_len_i                   number of 64-bit words to read
//   abort_i                     cancel the command in flight
//   out_valid_o / out_ready_i   read-data stream handshake
//   out_data_o, out_last_o      read word, final-word marker
//   busy_o                      a command is in progress
//   req_port_o_*                request fields towards the cache port
//   req_port_i_*                grant / response fields from the cache port
// -----------------------------------------------------------------------------
module dcache_burst_reader #(
  parameter int ADDR_W             = 56,
  parameter int LEN_W              = 8,
  parameter int DCACHE_INDEX_WIDTH = 12
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   cmd_valid_i,
  output logic                                   cmd_ready_o,
  input  logic [ADDR_W-1:0]                      cmd_addr_i,
  input  logic [LEN_W-1:0]                       cmd_len_i,
  input  logic                                   abort_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [63:0]                            out_data_o,
  output logic                                   out_last_o,
  output logic                                   busy_o,
  // request to cache port (dcache_req_i_t)
  output logic [DCACHE_INDEX_WIDTH-1:0]          req_port_o_address_index,
  output logic [ADDR_W-DCACHE_INDEX_WIDTH-1:0]   req_port_o_address_tag,
  output logic [63:0]                            req_port_o_data_wdata,
  output logic                                   req_port_o_data_req,
  output logic                                   req_port_o_data_we,
  output logic [7:0]                             req_port_o_data_be,
  output logic [1:0]                             req_port_o_data_size,
  output logic                                   req_port_o_kill_req,
  output logic                                   req_port_o_tag_valid,
  // response from cache port (dcache_req_o_t)
  input  logic                                   req_port_i_data_gnt,
  input  logic                                   req_port_i_data_rvalid,
  input  logic [63:0]                            req_port_i_data_rdata
);

  localparam int IDX_W = DCACHE_INDEX_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_TAG  = 3'd2,
    S_WAIT = 3'd3,
    S_HOLD = 3'd4,
    S_KILL = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [ADDR_W-1:0]  r_cur_addr;
  logic [LEN_W-1:0]   r_remaining;
  logic [63:0]        r_buf_data;
  logic               r_buf_last;
  logic               r_buf_full;

  logic               w_accept;     // command consumed this cycle
  logic               w_load;       // response word captured this cycle
  logic               w_drain;      // buffered word accepted downstream
  logic               w_clear;      // abort: drop buffered word
  logic               w_data_req;
  logic               w_tag_valid;
  logic               w_kill_req;

  // The low three address bits are intentionally discarded (word aligned).
  logic               w_unused_addr_lsb;
  assign w_unused_addr_lsb = ^cmd_addr_i[2:0];

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and cache-port strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_drain     = 1'b0;
    w_clear     = 1'b0;
    w_data_req  = 1'b0;
    w_tag_valid = 1'b0;
    w_kill_req  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // abort_i is meaningless here; a zero-length command is consumed
        // without touching the cache.
        if (cmd_valid_i) begin
          w_accept = 1'b1;
          if (cmd_len_i != {LEN_W{1'b0}}) begin
            w_state_nxt = S_REQ;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (abort_i) begin
          // data_req is dropped; a grant racing the abort still has to be
          // cancelled with a kill cycle instead of a tag phase.
          w_clear = 1'b1;
          if (req_port_i_data_gnt) begin
            w_state_nxt = S_KILL;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_data_req = 1'b1;
          if (req_port_i_data_gnt) begin
            w_state_nxt = S_TAG;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_TAG: begin
        w_clear = abort_i;
        if (abort_i) begin
          w_kill_req  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tag_valid = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort_i) begin
          w_clear     = 1'b1;
          w_kill_req  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (req_port_i_data_rvalid) begin
          // The buffer is always empty here (the next access is only issued
          // after the previous word drained), and the word being written
          // cannot drain in the same cycle, so the path always goes via HOLD.
          w_load      = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_HOLD: begin
        if (abort_i) begin
          w_clear     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (out_ready_i) begin
          w_drain = 1'b1;
          if (r_remaining != {LEN_W{1'b0}}) begin
            w_state_nxt = S_REQ;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_KILL: begin
        w_kill_req  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_clear     = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Address and word counter; address wraps modulo 2^ADDR_W, so an index
  // overflow naturally carries into the tag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cur_addr  <= {ADDR_W{1'b0}};
      r_remaining <= {LEN_W{1'b0}};
    end else if (w_accept) begin
      r_cur_addr  <= {cmd_addr_i[ADDR_W-1:3], 3'b000};
      r_remaining <= cmd_len_i;
    end else if (w_load) begin
      r_cur_addr  <= r_cur_addr + ADDR_W'(8);
      r_remaining <= r_remaining - LEN_W'(1);
    end else begin
      r_cur_addr  <= r_cur_addr;
      r_remaining <= r_remaining;
    end
  end

  // Single-entry output buffer; responses are only captured in WAIT, so a
  // late reply to a killed access can never load it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_buf_data <= 64'h0;
      r_buf_last <= 1'b0;
      r_buf_full <= 1'b0;
    end else if (w_clear || w_drain) begin
      r_buf_full <= 1'b0;
      r_buf_last <= 1'b0;
    end else if (w_load) begin
      r_buf_data <= req_port_i_data_rdata;
      r_buf_last <= (r_remaining == LEN_W'(1));
      r_buf_full <= 1'b1;
    end else begin
      r_buf_full <= r_buf_full;
    end
  end

  assign cmd_ready_o = (r_state == S_IDLE);
  assign busy_o      = (r_state != S_IDLE);
  assign out_valid_o = r_buf_full;
  assign out_data_o  = r_buf_data;
  assign out_last_o  = r_buf_last;

  assign req_port_o_address_index = r_cur_addr[IDX_W-1:0];
  assign req_port_o_address_tag   = r_cur_addr[ADDR_W-1:IDX_W];
  assign req_port_o_data_wdata    = 64'h0;
  assign req_port_o_data_req      = w_data_req;
  assign req_port_o_data_we       = 1'b0;
  assign req_port_o_data_be       = 8'hFF;
  assign req_port_o_data_size     = 2'b11;
  assign req_port_o_kill_req      = w_kill_req;
  assign req_port_o_tag_valid     = w_tag_valid;

endmodule

// File: tb/tb_dcache_burst_reader.sv
// -----------------------------------------------------------------------------
// Directed testbench for dcache_burst_reader. A small cache-port model grants
// requests after a programmable delay and answers each tag phase in the next
// cycle with data {8'hD0, tag, index}; it also logs what it observed. Each
// test task checks its own expectations inline.
// -----------------------------------------------------------------------------
module tb_dcache_burst_reader;
  localparam int ADDR_W = 56;
  localparam int LEN_W  = 8;
  localparam int IDX_W  = 12;
  localparam int TAG_W  = ADDR_W - IDX_W;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              cmd_valid_i = 1'b0;
  logic              cmd_ready_o;
  logic [ADDR_W-1:0] cmd_addr_i = '0;
  logic [LEN_W-1:0]  cmd_len_i = '0;
  logic              abort_i = 1'b0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [63:0]       out_data_o;
  logic              out_last_o;
  logic              busy_o;
  logic [IDX_W-1:0]  req_index;
  logic [TAG_W-1:0]  req_tag;
  logic [63:0]       req_wdata;
  logic              req_data_req;
  logic              req_we;
  logic [7:0]        req_be;
  logic [1:0]        req_size;
  logic              req_kill;
  logic              req_tag_valid;
  logic              rsp_gnt = 1'b0;
  logic              rsp_rvalid = 1'b0;
  logic [63:0]       rsp_rdata = 64'h0;

  always #5 clk_i = ~clk_i;

  dcache_burst_reader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DCACHE_INDEX_WIDTH(IDX_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .abort_i(abort_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o), .busy_o(busy_o),
    .req_port_o_address_index(req_index), .req_port_o_address_tag(req_tag),
    .req_port_o_data_wdata(req_wdata), .req_port_o_data_req(req_data_req),
    .req_port_o_data_we(req_we), .req_port_o_data_be(req_be),
    .req_port_o_data_size(req_size), .req_port_o_kill_req(req_kill),
    .req_port_o_tag_valid(req_tag_valid),
    .req_port_i_data_gnt(rsp_gnt), .req_port_i_data_rvalid(rsp_rvalid),
    .req_port_i_data_rdata(rsp_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  // cache model knobs and state
  int               gnt_delay = 0;
  int               gnt_cnt = 0;
  bit               suppress_rsp = 1'b0;
  bit               force_stray = 1'b0;
  bit               force_gnt = 1'b0;
  bit               rsp_due = 1'b0;
  logic [63:0]      rsp_data = 64'h0;
  logic [IDX_W-1:0] gnt_index = '0;
  logic [IDX_W-1:0] prev_index = '0;
  bit               req_prev = 1'b0;
  bit               idx_changed = 1'b0;
  int               n_req = 0;
  int               n_tag = 0;
  int               n_kill = 0;
  int               n_busy = 0;
  logic [IDX_W-1:0] q_idx[$];
  logic [TAG_W-1:0] q_tag[$];
  logic [63:0]      q_dat[$];
  logic             q_last[$];

  task automatic clear_logs();
    q_idx.delete(); q_tag.delete(); q_dat.delete(); q_last.delete();
    n_req = 0; n_tag = 0; n_kill = 0; n_busy = 0;
    gnt_cnt = 0; rsp_due = 1'b0; req_prev = 1'b0; idx_changed = 1'b0;
  endtask

  // One evaluation of the cache port per cycle, called after inputs are set.
  task automatic cache_drive();
    rsp_gnt = 1'b0; rsp_rvalid = 1'b0; rsp_rdata = 64'h0;
    if (force_stray) begin
      rsp_rvalid = 1'b1; rsp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    end else if (rsp_due) begin
      rsp_rvalid = 1'b1; rsp_rdata = rsp_data;
    end
    if (force_gnt) begin
      rsp_gnt = 1'b1;
    end else if (req_data_req) begin
      if (gnt_cnt >= gnt_delay) begin
        rsp_gnt = 1'b1; gnt_cnt = 0;
      end else begin
        gnt_cnt++;
      end
    end
    if (req_data_req) begin
      n_req++;
      if (req_prev && (req_index !== prev_index)) idx_changed = 1'b1;
    end
    req_prev = req_data_req && !rsp_gnt;
    prev_index = req_index;
    if (req_data_req && rsp_gnt) begin
      q_idx.push_back(req_index); gnt_index = req_index;
    end
    if (req_tag_valid) begin n_tag++; q_tag.push_back(req_tag); end
    if (req_kill) n_kill++;
    if (busy_o) n_busy++;
    if (out_valid_o && out_ready_i) begin
      q_dat.push_back(out_data_o); q_last.push_back(out_last_o);
    end
    rsp_due = req_tag_valid && !suppress_rsp;
    rsp_data = {8'hD0, req_tag, gnt_index};
    #1;
  endtask

  task automatic settle(); #1; cache_drive(); endtask
  task automatic tick(); @(posedge clk_i); #1; endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin settle(); tick(); end
  endtask

  task automatic issue(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    cmd_addr_i = a; cmd_len_i = l; cmd_valid_i = 1'b1;
    settle(); tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++; if (cmd_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready_o); end
    n_checks++; if (req_data_req !== 1'b0) begin n_errors++; $display("FAIL reset_data_req got %b exp 0", req_data_req); end
    n_checks++; if (req_tag_valid !== 1'b0) begin n_errors++; $display("FAIL reset_tag_valid got %b exp 0", req_tag_valid); end
    n_checks++; if (out_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    n_checks++; if (req_kill !== 1'b0) begin n_errors++; $display("FAIL reset_kill got %b exp 0", req_kill); end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    clear_logs(); gnt_delay = 0; out_ready_i = 1'b1;
    issue(56'h0000_1000_0FF8, 8'd2);
    run(12);
    n_checks++; if (q_idx.size() !== 2) begin n_errors++; $display("FAIL basic_n_access got %0d exp 2", q_idx.size()); end
    if (q_idx.size() == 2 && q_tag.size() == 2) begin
      n_checks++; if (q_idx[0] !== 12'hFF8) begin n_errors++; $display("FAIL basic_index0 got %h exp ff8", q_idx[0]); end
      n_checks++; if (q_tag[0] !== 44'h1_0000) begin n_errors++; $display("FAIL basic_tag0 got %h exp 10000", q_tag[0]); end
      n_checks++; if (q_idx[1] !== 12'h000) begin n_errors++; $display("FAIL basic_index1 got %h exp 000", q_idx[1]); end
      n_checks++; if (q_tag[1] !== 44'h1_0001) begin n_errors++; $display("FAIL basic_tag1 got %h exp 10001", q_tag[1]); end
    end
    n_checks++; if (q_dat.size() !== 2) begin n_errors++; $display("FAIL basic_n_words got %0d exp 2", q_dat.size()); end
    if (q_dat.size() == 2) begin
      n_checks++; if (q_dat[0] !== 64'hD000_0000_1000_0FF8) begin n_errors++; $display("FAIL basic_data0 got %h exp d000000010000ff8", q_dat[0]); end
      n_checks++; if (q_dat[1] !== 64'hD000_0000_1000_1000) begin n_errors++; $display("FAIL basic_data1 got %h exp d000000010001000", q_dat[1]); end
      n_checks++; if (q_last[0] !== 1'b0) begin n_errors++; $display("FAIL basic_last0 got %b exp 0", q_last[0]); end
      n_checks++; if (q_last[1] !== 1'b1) begin n_errors++; $display("FAIL basic_last1 got %b exp 1", q_last[1]); end
    end
    n_checks++; if (n_busy !== 8) begin n_errors++; $display("FAIL basic_busy_cycles got %0d exp 8", n_busy); end
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL basic_idle_after got %b exp 0", busy_o); end
  endtask

  task automatic test_stall();
    int waited;
    clear_logs(); out_ready_i = 1'b0;
    issue(56'h0000_0000_2000, 8'd3);
    waited = 0;
    while (waited < 10) begin
      settle();
      if (out_valid_o) break;
      tick(); waited++;
    end
    n_checks++; if (out_valid_o !== 1'b1) begin n_errors++; $display("FAIL stall_first_word_timeout got %b exp 1", out_valid_o); end
    for (int i = 0; i < 5; i++) begin
      if (i != 0) settle();
      n_checks++; if (req_data_req !== 1'b0) begin n_errors++; $display("FAIL stall_data_req cycle %0d got %b exp 0", i, req_data_req); end
      n_checks++; if (out_data_o !== 64'hD000_0000_0000_2000) begin n_errors++; $display("FAIL stall_data_hold cycle %0d got %h exp d000000000002000", i, out_data_o); end
      tick();
    end
    out_ready_i = 1'b1;
    run(20);
    n_checks++; if (q_dat.size() !== 3) begin n_errors++; $display("FAIL stall_n_words got %0d exp 3", q_dat.size()); end
    if (q_dat.size() == 3) begin
      n_checks++; if (q_dat[0] !== 64'hD000_0000_0000_2000) begin n_errors++; $display("FAIL stall_data0 got %h", q_dat[0]); end
      n_checks++; if (q_dat[1] !== 64'hD000_0000_0000_2008) begin n_errors++; $display("FAIL stall_data1 got %h", q_dat[1]); end
      n_checks++; if (q_dat[2] !== 64'hD000_0000_0000_2010) begin n_errors++; $display("FAIL stall_data2 got %h", q_dat[2]); end
      n_checks++; if ({q_last[0], q_last[1], q_last[2]} !== 3'b001) begin n_errors++; $display("FAIL stall_last got %b%b%b exp 001", q_last[0], q_last[1], q_last[2]); end
    end
  endtask

  task automatic test_gnt_delay();
    clear_logs(); gnt_delay = 4; out_ready_i = 1'b1;
    issue(56'h0000_0000_3010, 8'd1);
    run(15);
    gnt_delay = 0;
    n_checks++; if (n_req !== 5) begin n_errors++; $display("FAIL gnt_delay_req_cycles got %0d exp 5", n_req); end
    n_checks++; if (idx_changed !== 1'b0) begin n_errors++; $display("FAIL gnt_delay_index_stable got %b exp 0", idx_changed); end
    n_checks++; if (n_tag !== 1) begin n_errors++; $display("FAIL gnt_delay_tag_pulses got %0d exp 1", n_tag); end
    n_checks++; if (q_dat.size() !== 1) begin n_errors++; $display("FAIL gnt_delay_n_words got %0d exp 1", q_dat.size()); end
    if (q_dat.size() == 1) begin
      n_checks++; if (q_dat[0] !== 64'hD000_0000_0000_3010) begin n_errors++; $display("FAIL gnt_delay_data got %h", q_dat[0]); end
      n_checks++; if (q_last[0] !== 1'b1) begin n_errors++; $display("FAIL gnt_delay_last got %b exp 1", q_last[0]); end
    end
  endtask

  task automatic test_abort_wait();
    int waited;
    clear_logs(); suppress_rsp = 1'b1; out_ready_i = 1'b1;
    issue(56'h0000_0000_4000, 8'd2);
    waited = 0;
    while (waited < 10) begin
      settle();
      if (req_tag_valid) break;
      tick(); waited++;
    end
    n_checks++; if (req_tag_valid !== 1'b1) begin n_errors++; $display("FAIL abort_wait_tag_timeout got %b exp 1", req_tag_valid); end
    tick();
    abort_i = 1'b1;
    settle();
    n_checks++; if (req_kill !== 1'b1) begin n_errors++; $display("FAIL abort_wait_kill got %b exp 1", req_kill); end
    tick();
    abort_i = 1'b0;
    settle();
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL abort_wait_idle got %b exp 0", busy_o); end
    n_checks++; if (req_kill !== 1'b0) begin n_errors++; $display("FAIL abort_wait_kill_once got %b exp 0", req_kill); end
    tick();
    force_stray = 1'b1;
    settle(); tick();
    force_stray = 1'b0;
    settle();
    n_checks++; if (out_valid_o !== 1'b0) begin n_errors++; $display("FAIL abort_wait_stray got %b exp 0", out_valid_o); end
    tick();
    n_checks++; if (n_kill !== 1) begin n_errors++; $display("FAIL abort_wait_kill_count got %0d exp 1", n_kill); end
    suppress_rsp = 1'b0;
    clear_logs();
    issue(56'h0000_0000_5008, 8'd1);
    run(10);
    n_checks++; if (q_dat.size() !== 1) begin n_errors++; $display("FAIL abort_wait_next_n got %0d exp 1", q_dat.size()); end
    if (q_dat.size() == 1) begin
      n_checks++; if (q_dat[0] !== 64'hD000_0000_0000_5008) begin n_errors++; $display("FAIL abort_wait_next_data got %h", q_dat[0]); end
    end
  endtask

  task automatic test_abort_req_gnt();
    clear_logs(); out_ready_i = 1'b1;
    issue(56'h0000_0000_7000, 8'd1);
    abort_i = 1'b1; force_gnt = 1'b1;
    settle();
    n_checks++; if (req_data_req !== 1'b0) begin n_errors++; $display("FAIL abort_req_drop got %b exp 0", req_data_req); end
    tick();
    abort_i = 1'b0; force_gnt = 1'b0;
    settle();
    n_checks++; if (req_kill !== 1'b1) begin n_errors++; $display("FAIL abort_req_kill got %b exp 1", req_kill); end
    n_checks++; if (req_tag_valid !== 1'b0) begin n_errors++; $display("FAIL abort_req_no_tag got %b exp 0", req_tag_valid); end
    tick();
    settle();
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL abort_req_idle got %b exp 0", busy_o); end
    tick();
  endtask

  task automatic test_len0();
    clear_logs();
    cmd_addr_i = 56'h0000_0000_6000; cmd_len_i = 8'd0; cmd_valid_i = 1'b1;
    settle();
    n_checks++; if (cmd_ready_o !== 1'b1) begin n_errors++; $display("FAIL len0_accept got %b exp 1", cmd_ready_o); end
    tick();
    cmd_valid_i = 1'b0;
    run(6);
    n_checks++; if (n_req !== 0) begin n_errors++; $display("FAIL len0_no_req got %0d exp 0", n_req); end
    n_checks++; if (n_busy !== 0) begin n_errors++; $display("FAIL len0_busy got %0d exp 0", n_busy); end
    n_checks++; if (q_dat.size() !== 0) begin n_errors++; $display("FAIL len0_no_out got %0d exp 0", q_dat.size()); end
  endtask

  task automatic test_wrap();
    clear_logs(); out_ready_i = 1'b1;
    issue(56'hFF_FFFF_FFFF_FFF8, 8'd2);
    run(12);
    n_checks++; if (q_idx.size() !== 2 || q_tag.size() !== 2) begin n_errors++; $display("FAIL wrap_n_access got %0d/%0d exp 2/2", q_idx.size(), q_tag.size()); end
    if (q_idx.size() == 2 && q_tag.size() == 2) begin
      n_checks++; if (q_tag[0] !== 44'hFFF_FFFF_FFFF) begin n_errors++; $display("FAIL wrap_tag0 got %h exp fffffffffff", q_tag[0]); end
      n_checks++; if (q_idx[1] !== 12'h000) begin n_errors++; $display("FAIL wrap_index1 got %h exp 000", q_idx[1]); end
      n_checks++; if (q_tag[1] !== 44'h0) begin n_errors++; $display("FAIL wrap_tag1 got %h exp 0", q_tag[1]); end
    end
    if (q_dat.size() == 2) begin
      n_checks++; if (q_dat[0] !== 64'hD0FF_FFFF_FFFF_FFF8) begin n_errors++; $display("FAIL wrap_data0 got %h", q_dat[0]); end
      n_checks++; if (q_dat[1] !== 64'hD000_0000_0000_0000) begin n_errors++; $display("FAIL wrap_data1 got %h", q_dat[1]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs(); out_ready_i = 1'b1;
    issue(56'h0000_0000_8000, 8'd4);
    run(3);
    rst_ni = 1'b0;
    #1;
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_mid_busy got %b exp 0", busy_o); end
    n_checks++; if (out_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_mid_out_valid got %b exp 0", out_valid_o); end
    n_checks++; if (req_kill !== 1'b0) begin n_errors++; $display("FAIL reset_mid_kill got %b exp 0", req_kill); end
    n_checks++; if (cmd_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_mid_cmd_ready got %b exp 1", cmd_ready_o); end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    tick();
    clear_logs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_gnt_delay();
    test_abort_wait();
    test_abort_req_gnt();
    test_len0();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
